// File: rtl/sram_bus_arbiter_if.sv
// Signal bundle between the IF/MEM memory ports, the arbiter and the shared SRAM-like bus.
// The arbiter connects through the master modport; the pipeline/bus-slave side uses slave.
interface sram_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic        stallreq_mem;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stallreq_mem
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stallreq_mem
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-port (IF/MEM) arbiter onto a single SRAM-like bus, one transaction in flight at most.
// Define ARB_RR_EN for round-robin grant; otherwise data has fixed priority over inst.
module sram_bus_arbiter (
    input  logic clk,
    input  logic resetn,
    sram_bus_arbiter_if.master port
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;
    logic        accept;
    logic        grant_inst;
    logic        grant_data;
    logic        grant_any;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

`ifdef ARB_RR_EN
    logic last_grant;

    // On a tie the requester that was not served last wins; last_grant = 1 means data.
    always_comb begin
        grant_data = port.data_req & (~port.inst_req | ~last_grant);
        grant_inst = port.inst_req & ~grant_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_data;
        end
    end
`else
    always_comb begin
        grant_data = port.data_req;
        grant_inst = port.inst_req & ~port.data_req;
    end
`endif

    assign grant_any = grant_inst | grant_data;

    always_comb begin
        state_next        = state;
        accept            = 1'b0;
        port.inst_addr_ok = 1'b0;
        port.data_addr_ok = 1'b0;
        port.inst_data_ok = 1'b0;
        port.data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    accept            = 1'b1;
                    port.inst_addr_ok = grant_inst;
                    port.data_addr_ok = grant_data;
                    state_next        = ADDR;
                end
            end
            ADDR: begin
                if (port.bus_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // The response is steered only to the owner; the other side never sees data_ok.
                if (port.bus_data_ok) begin
                    port.inst_data_ok = ~owner;
                    port.data_data_ok = owner;
                    state_next        = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= grant_data;
                if (grant_data) begin
                    wr_q    <= port.data_wr;
                    size_q  <= port.data_size;
                    wstrb_q <= port.data_wr ? port.data_wstrb : 4'd0;
                    addr_q  <= port.data_addr;
                    wdata_q <= port.data_wdata;
                end else begin
                    // Instruction fetches are always word-sized loads.
                    wr_q    <= 1'b0;
                    size_q  <= 2'd2;
                    wstrb_q <= 4'd0;
                    addr_q  <= port.inst_addr;
                    wdata_q <= 32'd0;
                end
            end
        end
    end

    // bus_req decodes straight from state so an asynchronous reset drops it immediately.
    assign port.bus_req      = (state == ADDR);
    assign port.bus_wr       = wr_q;
    assign port.bus_size     = size_q;
    assign port.bus_wstrb    = wstrb_q;
    assign port.bus_addr     = addr_q;
    assign port.bus_wdata    = wdata_q;

    assign port.inst_rdata   = port.bus_rdata;
    assign port.data_rdata   = port.bus_rdata;

    assign port.stallreq_mem = port.data_req | (owner & (state != IDLE));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a bus-slave model and a request/response scoreboard.
module tb_sram_bus_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_bus_arbiter_if ifc ();

    sram_bus_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .port   (ifc)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        iq[$];
    req_t        dq[$];
    req_t        be[$];
    logic [31:0] ie[$];
    logic [31:0] de[$];
    int          iaok[$];
    int          idok[$];
    int          daok[$];
    int          ddok[$];
    int          stl[$];
    int          breq_n;

    int          sl_wait;
    int          sl_cnt;
    bit          sl_pend;
    bit          spur;
    logic [31:0] sl_rd;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          t0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int e[$]);
        bit ok;
        ok = (q.size() == e.size());
        if (ok) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i] != e[i]) ok = 1'b0;
            end
        end
        n_tests++;
        assert (ok)
        else begin
            n_fail++;
            $error("FAIL %s: observed %p expected %p", tag, q, e);
        end
    endtask

    task automatic begin_test();
        iaok.delete();
        idok.delete();
        daok.delete();
        ddok.delete();
        stl.delete();
        breq_n = 0;
        t0     = cyc + 1;
    endtask

    task automatic step();
        req_t r;
        req_t e;
        int   rel;
        @(posedge clk);
        #1;
        cyc++;
        // bus slave: data_ok one cycle after an accepted address, after sl_wait stalls
        ifc.bus_data_ok = sl_pend | spur;
        if (sl_pend) ifc.bus_rdata = sl_rd;
        sl_pend = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        if (ifc.bus_req) begin
            if (sl_cnt < sl_wait) begin
                sl_cnt++;
            end else begin
                ifc.bus_addr_ok = 1'b1;
                sl_cnt  = 0;
                sl_pend = 1'b1;
                sl_rd   = mem_f(ifc.bus_addr);
            end
        end
        // requesters hold their request until accepted
        ifc.inst_req  = (iq.size() > 0);
        ifc.inst_addr = (iq.size() > 0) ? iq[0].addr : 32'd0;
        ifc.data_req  = (dq.size() > 0);
        if (dq.size() > 0) begin
            ifc.data_wr    = dq[0].wr;
            ifc.data_size  = dq[0].size;
            ifc.data_wstrb = dq[0].wstrb;
            ifc.data_addr  = dq[0].addr;
            ifc.data_wdata = dq[0].wdata;
        end
        @(negedge clk);
        rel = cyc - t0;
        if (ifc.inst_addr_ok) begin
            iaok.push_back(rel);
            if (iq.size() == 0) chk("inst_addr_ok_unrequested", 1, 0);
            else begin
                r = iq.pop_front();
                e = '{1'b0, 2'd2, 4'd0, r.addr, 32'd0};
                be.push_back(e);
                ie.push_back(mem_f(r.addr));
            end
        end
        if (ifc.data_addr_ok) begin
            daok.push_back(rel);
            if (dq.size() == 0) chk("data_addr_ok_unrequested", 1, 0);
            else begin
                r = dq.pop_front();
                e = r;
                if (!r.wr) e.wstrb = 4'd0;
                be.push_back(e);
                de.push_back(mem_f(r.addr));
            end
        end
        if (ifc.bus_req) begin
            breq_n++;
            if (be.size() == 0) chk("bus_req_unexpected", 1, 0);
            else begin
                chk("bus_fields",
                    {ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb, ifc.bus_addr, ifc.bus_wdata},
                    {be[0].wr, be[0].size, be[0].wstrb, be[0].addr, be[0].wdata});
                if (ifc.bus_addr_ok) void'(be.pop_front());
            end
        end
        if (ifc.inst_data_ok) begin
            idok.push_back(rel);
            if (ie.size() == 0) chk("inst_data_ok_unexpected", 1, 0);
            else chk("inst_rdata", ifc.inst_rdata, ie.pop_front());
        end
        if (ifc.data_data_ok) begin
            ddok.push_back(rel);
            if (de.size() == 0) chk("data_data_ok_unexpected", 1, 0);
            else chk("data_rdata", ifc.data_rdata, de.pop_front());
        end
        if (ifc.inst_data_ok && ifc.data_data_ok) chk("both_data_ok", 1, 0);
        if (ifc.stallreq_mem) stl.push_back(rel);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {ifc.bus_req, ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb, ifc.bus_addr, ifc.bus_wdata,
                  ifc.inst_addr_ok, ifc.data_addr_ok, ifc.inst_data_ok, ifc.data_data_ok, ifc.stallreq_mem},
            76'd0);
    endtask

    initial begin
        ifc.inst_req    = 1'b0;
        ifc.inst_addr   = 32'd0;
        ifc.data_req    = 1'b0;
        ifc.data_wr     = 1'b0;
        ifc.data_size   = 2'd0;
        ifc.data_wstrb  = 4'd0;
        ifc.data_addr   = 32'd0;
        ifc.data_wdata  = 32'd0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = 32'd0;
        sl_wait = 0; sl_cnt = 0; sl_pend = 1'b0; spur = 1'b0; sl_rd = 32'd0;
        n_tests = 0; n_fail = 0; cyc = 0; t0 = 0; breq_n = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_values");
        resetn = 1'b1;

        // simultaneous requests (first tie after reset)
        begin_test();
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_1000, 32'd0});
        dq.push_back('{1'b0, 2'd2, 4'hF, 32'h0000_2000, 32'd0});
        repeat (8) step();
`ifdef ARB_RR_EN
        chk_q("tie_inst_addr_ok", iaok, '{0});
        chk_q("tie_inst_data_ok", idok, '{2});
        chk_q("tie_data_addr_ok", daok, '{3});
        chk_q("tie_data_data_ok", ddok, '{5});
`else
        chk_q("tie_data_addr_ok", daok, '{0});
        chk_q("tie_data_data_ok", ddok, '{2});
        chk_q("tie_inst_addr_ok", iaok, '{3});
        chk_q("tie_inst_data_ok", idok, '{5});
`endif

        // single load, zero-wait slave
        begin_test();
        dq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0104, 32'd0});
        repeat (5) step();
        chk_q("load_addr_ok", daok, '{0});
        chk_q("load_data_ok", ddok, '{2});
        chk("load_no_inst_data_ok", idok.size(), 0);
        chk_q("load_stall", stl, '{0, 1, 2});

        // store with three address wait states
        sl_wait = 3;
        begin_test();
        dq.push_back('{1'b1, 2'd2, 4'h3, 32'h0000_0200, 32'h1234_5678});
        repeat (8) step();
        sl_wait = 0;
        chk("store_bus_req_cycles", breq_n, 4);
        chk_q("store_data_ok", ddok, '{5});

        // bus_data_ok while idle is ignored
        begin_test();
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spurious_no_data_ok", idok.size() + ddok.size(), 0);
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0400, 32'd0});
        repeat (5) step();
        chk_q("spurious_then_addr_ok", iaok, '{1});
        chk_q("spurious_then_data_ok", idok, '{3});

        // repeated fetches, zero-wait slave
        begin_test();
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0100, 32'd0});
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0104, 32'd0});
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0108, 32'd0});
        repeat (10) step();
        chk_q("fetch_addr_ok", iaok, '{0, 3, 6});
        chk_q("fetch_data_ok", idok, '{2, 5, 8});

        // reset during ADDR
        sl_wait = 5;
        begin_test();
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'h0000_0300, 32'd0});
        step();
        step();
        chk("addr_phase_bus_req", ifc.bus_req, 1);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("mid_reset_values");
        iq.delete(); dq.delete(); be.delete(); ie.delete(); de.delete();
        sl_cnt = 0; sl_pend = 1'b0; sl_wait = 0;
        begin_test();
        step();
        chk("reset_no_data_ok", idok.size() + ddok.size(), 0);
        resetn = 1'b1;
        begin_test();
        iq.push_back('{1'b0, 2'd2, 4'd0, 32'hBFC0_0000, 32'd0});
        repeat (4) step();
        chk_q("post_reset_addr_ok", iaok, '{0});
        chk_q("post_reset_data_ok", idok, '{2});

        chk("scoreboard_drained", {iq.size(), dq.size(), be.size(), ie.size(), de.size()}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-port arbiter placed between the pipeline's memory ports and the single SRAM-like bus of the CPU top. Instruction fetch (IF) and data access (MEM) each present a request/addr_ok/data_ok port. The block grants one requester at a time, sequences one transaction on the shared bus, and routes the response back to the owner. It also produces a MEM-side stall request while a data access is outstanding.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  IF request, held until inst_addr_ok
- inst_addr  in  32  IF word address
- inst_addr_ok  out  1  one-cycle pulse: IF request accepted
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetched instruction
- data_req  in  1  MEM request, held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  store byte enables
- data_addr  in  32  data byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  one-cycle pulse: MEM request accepted
- data_data_ok  out  1  one-cycle pulse: load data valid or store complete
- data_rdata  out  32  raw 32-bit read word; the MEM stage does lane extraction
- bus_req  out  1  bus request
- bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/2/4/32/32  registered copy of the granted request
- bus_addr_ok  in  1  bus accepted the address phase
- bus_data_ok  in  1  bus response
- bus_rdata  in  32  bus read data
- stallreq_mem  out  1  high from data_req until data_data_ok, inclusive of the acceptance cycle

## Operation
- FSM states: IDLE, ADDR, DATA. There is one transaction in flight at most.
- IDLE:
  - If any request is present, grant one requester.
  - Latch its fields into the bus_* registers and record the owner in a 1-bit register (0 = inst, 1 = data).
  - Pulse that requester's addr_ok in the same cycle.
  - Next state is ADDR.
  - With no request, stay in IDLE.
- ADDR: hold bus_req = 1 with the latched fields. When bus_addr_ok is sampled high, drop bus_req and go to DATA.
- DATA: wait for bus_data_ok. On that cycle:
  - Drive the owner's data_ok = 1 and rdata = bus_rdata combinationally.
  - Return to IDLE.
- The non-owner's data_ok is always 0. inst_rdata and data_rdata both equal bus_rdata; only the data_ok pulses qualify them.
- Grant policy (default): data has fixed priority over inst when both request in IDLE.
- Loads use wstrb = 0 on the bus regardless of data_wstrb. Stores forward data_wstrb unchanged.
- bus_data_ok outside DATA is ignored. It causes no pulse and no state change.
- stallreq_mem = data_req | (owner == data && state != IDLE).

## Timing
- Reset values: state = IDLE, owner = 0, bus_req = 0, bus_wr = 0, bus_size = 0, bus_wstrb = 0, bus_addr = 0, bus_wdata = 0. All *_addr_ok and *_data_ok outputs are 0.
- Reset asserted mid-transaction aborts immediately: bus_req falls asynchronously and no data_ok is produced. The bus slave shares resetn.
- Minimum transaction, with addr_ok and data_ok each returned in their first possible cycle:
  - cycle 0: request accepted (addr_ok pulse)
  - cycle 1: bus_req high, bus_addr_ok high
  - cycle 2: bus_data_ok high, requester data_ok
  - cycle 3: IDLE; a new grant is possible
- Back-to-back throughput: one transaction every 3 cycles.
- bus_req stays high with stable fields until bus_addr_ok, for any number of wait cycles.
- A requester whose req is low in IDLE is never granted. A request raised in the ADDR or DATA state waits for IDLE.

## Configuration
- ARB_RR_EN defined:
  - Round-robin between the two requesters. A 1-bit last_grant register resets to 1 (data), so inst wins the first tie after reset.
  - On every grant, last_grant is updated; when both request, the one not last granted wins.
- ARB_RR_EN undefined: fixed data priority as described in Operation. No last_grant register.

## Test plan
- Single load: data_req = 1, addr = 0x0000_0104, size = 2; slave gives addr_ok in cycle 1 and data_ok with rdata = 0xDEAD_BEEF in cycle 2 → data_addr_ok at cycle 0, data_data_ok at cycle 2 with data_rdata = 0xDEAD_BEEF, inst_data_ok = 0 throughout, stallreq_mem high during cycles 0–2.
- Store with wait states: data_wr = 1, wstrb = 0x3, wdata = 0x1234_5678; slave holds addr_ok low for 3 cycles → bus_req high for 4 cycles with stable fields; one data_data_ok pulse after bus_data_ok.
- Simultaneous requests, inst_req and data_req both high at cycle 0:
  - default: data is served first, inst is accepted at cycle 3;
  - with ARB_RR_EN: inst is served first, then data.
- Spurious response: bus_data_ok = 1 while in IDLE → no data_ok pulse, state remains IDLE.
- Reset mid-operation: resetn low during ADDR → bus_req = 0 within the same cycle, all outputs at reset values; after release, a fresh inst fetch of 0xBFC0_0000 completes normally.
- Repeated fetches: inst_req held high for 9 cycles with a zero-wait slave → exactly 3 inst_addr_ok pulses and 3 inst_data_ok pulses, in order.
